// File: rtl/fifo_param_mem.sv
// Register file backing fifo_param: DATA_W x DEPTH storage with a
// synchronous write port and an asynchronous (combinational) read port.
// Contents are intentionally not reset; the control logic never exposes
// an entry that was not written since the last reset or flush.
module fifo_param_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the addressed entry on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[w_addr] <= wdata;
    end
  end

  // Show-ahead read: the addressed entry is visible without a clock.
  assign rdata = mem[r_addr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised show-ahead FIFO with level count, almost-full/almost-empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
//
// Handshake: there is no ready signal. A push is accepted when the FIFO is
// not full, or when it is full and a pop is accepted in the same cycle. A
// pop is accepted when the FIFO is not empty; pop acknowledges the word
// currently shown on pop_data. Rejected requests set the matching sticky
// flag. Acceptance is decided only from registered state, so all flags are
// free of combinational paths from push/pop.
module fifo_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = ADDR_W + 1;
  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_LEVEL);
  localparam logic [PTR_W-1:0] ONE_C   = PTR_W'(1);

  logic [PTR_W-1:0] w_ptr;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] count_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             push_ok;
  logic             pop_ok;

  // Status derived only from the registered count.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Pointers, level and sticky flags; flush overrides any same-cycle request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr       <= '0;
      r_ptr       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (flush) begin
      w_ptr       <= '0;
      r_ptr       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        w_ptr <= w_ptr + ONE_C;
      end
      if (pop_ok) begin
        r_ptr <= r_ptr + ONE_C;
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + ONE_C;
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - ONE_C;
      end
      if (push && !push_ok) begin
        overflow_q <= 1'b1;
      end
      if (pop && !pop_ok) begin
        underflow_q <= 1'b1;
      end
    end
  end

  fifo_param_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk    (clk),
    .wr_en  (push_ok & ~flush),
    .w_addr (w_ptr[ADDR_W-1:0]),
    .wdata  (push_data),
    .r_addr (r_ptr[ADDR_W-1:0]),
    .rdata  (pop_data)
  );

endmodule

// File: tb/tb_fifo_param.sv
// Directed testbench for fifo_param (DATA_W=8, ADDR_W=4, AF=14, AE=2).
module tb_fifo_param;

  logic       clk;
  logic       rst_n;
  logic       push;
  logic [7:0] push_data;
  logic       pop;
  logic [7:0] pop_data;
  logic       flush;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int passed = 0;

  logic [7:0] exp_q[$];

  fifo_param #(
    .DATA_W   (8),
    .ADDR_W   (4),
    .AF_LEVEL (14),
    .AE_LEVEL (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push),
    .push_data    (push_data),
    .pop          (pop),
    .pop_data     (pop_data),
    .flush        (flush),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: apply one cycle of requests, return 1 time unit after the edge.
  task automatic cycle(input logic p, input logic [7:0] d, input logic q, input logic f);
    push      = p;
    push_data = d;
    pop       = q;
    flush     = f;
    @(posedge clk);
    #1;
    push  = 1'b0;
    pop   = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", empty); else passed++;
    checks++; if (almost_empty !== 1'b1) $display("FAIL reset_almost_empty got=%b exp=1", almost_empty); else passed++;
    checks++; if (count !== 5'd0) $display("FAIL reset_count got=%0d exp=0", count); else passed++;
    checks++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else passed++;
    checks++; if (almost_full !== 1'b0) $display("FAIL reset_almost_full got=%b exp=0", almost_full); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else passed++;
    checks++; if (underflow !== 1'b0) $display("FAIL reset_underflow got=%b exp=0", underflow); else passed++;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      checks++; if (count !== 5'(i + 1)) $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i + 1); else passed++;
      checks++; if (almost_full !== (i + 1 >= 14)) $display("FAIL fill_almost_full n=%0d got=%b", i + 1, almost_full); else passed++;
      checks++; if (full !== (i + 1 == 16)) $display("FAIL fill_full n=%0d got=%b", i + 1, full); else passed++;
      checks++; if (almost_empty !== (i + 1 <= 2)) $display("FAIL fill_almost_empty n=%0d got=%b", i + 1, almost_empty); else passed++;
    end
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b1) $display("FAIL overflow_set got=%b exp=1", overflow); else passed++;
    checks++; if (count !== 5'd16) $display("FAIL overflow_count got=%0d exp=16", count); else passed++;
    for (int i = 0; i < 16; i++) begin
      checks++; if (pop_data !== 8'(i)) $display("FAIL drain_data i=%0d got=%h exp=%h", i, pop_data, 8'(i)); else passed++;
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (empty !== 1'b1) $display("FAIL drain_empty got=%b exp=1", empty); else passed++;
    checks++; if (underflow !== 1'b0) $display("FAIL drain_underflow got=%b exp=0", underflow); else passed++;
    checks++; if (overflow !== 1'b1) $display("FAIL overflow_sticky got=%b exp=1", overflow); else passed++;
  endtask

  task automatic test_simultaneous();
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    // Full: push and pop together
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    checks++; if (count !== 5'd16) $display("FAIL full_pp_count got=%0d exp=16", count); else passed++;
    checks++; if (pop_data !== 8'h11) $display("FAIL full_pp_head got=%h exp=11", pop_data); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL full_pp_overflow got=%b exp=0", overflow); else passed++;
    for (int i = 1; i < 16; i++) begin
      checks++; if (pop_data !== 8'(8'h10 + i)) $display("FAIL full_pp_drain i=%0d got=%h exp=%h", i, pop_data, 8'(8'h10 + i)); else passed++;
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (pop_data !== 8'hAA) $display("FAIL full_pp_tail got=%h exp=aa", pop_data); else passed++;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (empty !== 1'b1) $display("FAIL full_pp_empty got=%b exp=1", empty); else passed++;
    // Empty: push and pop together
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    checks++; if (count !== 5'd1) $display("FAIL empty_pp_count got=%0d exp=1", count); else passed++;
    checks++; if (pop_data !== 8'h55) $display("FAIL empty_pp_data got=%h exp=55", pop_data); else passed++;
    checks++; if (underflow !== 1'b1) $display("FAIL empty_pp_underflow got=%b exp=1", underflow); else passed++;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    // Mid level: count 5
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (pop_data !== 8'(8'h60 + i)) $display("FAIL mid_pp_head i=%0d got=%h exp=%h", i, pop_data, 8'(8'h60 + i)); else passed++;
      cycle(1'b1, 8'(8'h65 + i), 1'b1, 1'b0);
      checks++; if (count !== 5'd5) $display("FAIL mid_pp_count i=%0d got=%0d exp=5", i, count); else passed++;
    end
    for (int i = 3; i < 8; i++) begin
      checks++; if (pop_data !== 8'(8'h60 + i)) $display("FAIL mid_pp_drain i=%0d got=%h exp=%h", i, pop_data, 8'(8'h60 + i)); else passed++;
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checks++; if (empty !== 1'b1) $display("FAIL mid_pp_empty got=%b exp=1", empty); else passed++;
  endtask

  // Scoreboard-driven streaming across pointer rollover.
  task automatic test_wrap();
    int pushed = 0;
    int m_cnt  = 0;
    int cyc    = 0;
    logic p, q;
    logic [7:0] d;
    exp_q.delete();
    while ((pushed < 40 || m_cnt > 0) && cyc < 300) begin
      p = (pushed < 40) && (m_cnt < 10) && (cyc % 4 != 3);
      q = ((m_cnt > 3) && (cyc % 3 != 0)) || ((pushed == 40) && (m_cnt > 0));
      d = 8'(pushed * 7 + 3);
      if (q) begin
        checks++; if (pop_data !== exp_q[0]) $display("FAIL wrap_data cyc=%0d got=%h exp=%h", cyc, pop_data, exp_q[0]); else passed++;
        void'(exp_q.pop_front());
        m_cnt--;
      end
      if (p) begin
        exp_q.push_back(d);
        pushed++;
        m_cnt++;
      end
      cycle(p, d, q, 1'b0);
      checks++; if (count !== 5'(m_cnt)) $display("FAIL wrap_count cyc=%0d got=%0d exp=%0d", cyc, count, m_cnt); else passed++;
      checks++; if (full !== 1'b0) $display("FAIL wrap_full cyc=%0d got=%b exp=0", cyc, full); else passed++;
      cyc++;
    end
    checks++; if (cyc >= 300) $display("FAIL wrap_timeout cyc=%0d limit=300", cyc); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL wrap_empty got=%b exp=1", empty); else passed++;
  endtask

  task automatic test_flush();
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
    checks++; if (count !== 5'd9) $display("FAIL flush_pre_count got=%0d exp=9", count); else passed++;
    checks++; if (underflow !== 1'b1) $display("FAIL flush_pre_underflow got=%b exp=1", underflow); else passed++;
    cycle(1'b1, 8'h33, 1'b1, 1'b1);
    checks++; if (count !== 5'd0) $display("FAIL flush_count got=%0d exp=0", count); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL flush_empty got=%b exp=1", empty); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL flush_overflow got=%b exp=0", overflow); else passed++;
    checks++; if (underflow !== 1'b0) $display("FAIL flush_underflow got=%b exp=0", underflow); else passed++;
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    checks++; if (pop_data !== 8'h77) $display("FAIL flush_next_data got=%h exp=77", pop_data); else passed++;
    checks++; if (count !== 5'd1) $display("FAIL flush_next_count got=%0d exp=1", count); else passed++;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
    checks++; if (count !== 5'd7) $display("FAIL arst_pre_count got=%0d exp=7", count); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 5'd0) $display("FAIL arst_count got=%0d exp=0", count); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL arst_empty got=%b exp=1", empty); else passed++;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, 8'hC3, 1'b0, 1'b0);
    cycle(1'b1, 8'hC4, 1'b0, 1'b0);
    checks++; if (pop_data !== 8'hC3) $display("FAIL arst_after_data got=%h exp=c3", pop_data); else passed++;
    checks++; if (count !== 5'd2) $display("FAIL arst_after_count got=%0d exp=2", count); else passed++;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (pop_data !== 8'hC4) $display("FAIL arst_after_next got=%h exp=c4", pop_data); else passed++;
  endtask

  initial begin
    rst_n     = 1'b0;
    push      = 1'b0;
    push_data = 8'h00;
    pop       = 1'b0;
    flush     = 1'b0;
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
